// File: rtl/fp_other_pkg.sv
// Shared types and helpers for the FP "other" pipe:
// op codes, rounding modes, flag bundle, class flags, LZC and rounding.
package fp_other_pkg;

    typedef enum logic [3:0] {
        FPU_FSGNJ    = 4'd0,
        FPU_FSGNJN   = 4'd1,
        FPU_FSGNJX   = 4'd2,
        FPU_FMIN     = 4'd3,
        FPU_FMAX     = 4'd4,
        FPU_FEQ      = 4'd5,
        FPU_FLT      = 4'd6,
        FPU_FLE      = 4'd7,
        FPU_FCLASS   = 4'd8,
        FPU_FMV_XW   = 4'd9,
        FPU_FMV_WX   = 4'd10,
        FPU_FCVT_WS  = 4'd11,
        FPU_FCVT_WUS = 4'd12,
        FPU_FCVT_SW  = 4'd13,
        FPU_FCVT_SWU = 4'd14
    } FPU_Code;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } Rounding_Mode;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } FFlags_Path;

    typedef struct packed {
        logic is_zero;
        logic is_sub;
        logic is_norm;
        logic is_inf;
        logic is_snan;
        logic is_qnan;
        logic sign;
    } FpClass;

    localparam int LZC_WIDTH = 128;

    function automatic int fp_width(input int e, input int m);
        return 1 + e + m;
    endfunction

    // Canonical NaN in the low 1+e+m bits of a wide word.
    function automatic logic [LZC_WIDTH-1:0] canon_nan(input int e, input int m);
        logic [LZC_WIDTH-1:0] one;
        one = LZC_WIDTH'(1);
        return (((one << e) - one) << m) | (one << (m - 1));
    endfunction

    function automatic logic round_up(
        input Rounding_Mode rm,
        input logic sign,
        input logic lsb,
        input logic guard,
        input logic sticky
    );
        logic up;
        case (rm)
            RM_RNE:  up = guard & (sticky | lsb);
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = sign & (guard | sticky);
            RM_RUP:  up = ~sign & (guard | sticky);
            RM_RMM:  up = guard;
            default: up = 1'b0;
        endcase
        return up;
    endfunction

    // Operand is left-aligned at bit LZC_WIDTH-1.
    function automatic logic [7:0] lzc(input logic [LZC_WIDTH-1:0] v);
        logic [7:0] n;
        logic found;
        n = '0;
        found = 1'b0;
        for (int i = LZC_WIDTH - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else n = n + 8'd1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fp_other_compute.sv
// Combinational stage 0: sign-inject, min/max, compare, classify,
// move and int<->float conversion for a generic float format.
module fp_other_compute
    import fp_other_pkg::*;
#(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int INT_WIDTH  = 32
) (
    input  FPU_Code                op,
    input  Rounding_Mode           rm,
    input  logic [INT_WIDTH-1:0]   lhs,
    input  logic [INT_WIDTH-1:0]   rhs,
    output logic [INT_WIDTH-1:0]   result,
    output FFlags_Path             fflags
);
    localparam int EW = EXP_WIDTH;
    localparam int MW = MANT_WIDTH;
    localparam int IW = INT_WIDTH;
    localparam int FW = fp_width(EW, MW);
    localparam int BIAS = (1 << (EW - 1)) - 1;
    localparam int EXP_MAX = (1 << EW) - 1;
    localparam int FXW = IW + MW + 1;
    localparam logic [LZC_WIDTH-1:0] CNAN_W = canon_nan(EW, MW);
    localparam logic [FW-1:0] CNAN = CNAN_W[FW-1:0];
    localparam logic [IW-1:0] STK_MASK = (IW'(1) << (IW - 2 - MW)) - IW'(1);
    localparam logic [IW:0] S_POS_LIM = {2'b00, {(IW-1){1'b1}}};
    localparam logic [IW:0] S_NEG_LIM = {2'b01, {(IW-1){1'b0}}};
    localparam logic [IW-1:0] S_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic [IW-1:0] S_MIN = {1'b1, {(IW-1){1'b0}}};

    logic [FW-1:0] a_f, b_f, mm_f;
    FpClass a_c, b_c;
    logic a_nan, b_nan, any_snan, lt, eq;

    logic i2f_sign, i2f_zero, i2f_g, i2f_s, i2f_up, i2f_inf;
    logic [IW-1:0] i2f_mag, i2f_norm;
    logic [LZC_WIDTH-1:0] i2f_t;
    logic [7:0] i2f_lz;
    logic [MW:0] i2f_mant;
    int i2f_exp;
    logic [FW-1:0] i2f_res;
    FFlags_Path i2f_flags;

    logic f_signed, f_sign, f_big, f_g, f_st, f_up;
    int f_ue;
    logic [MW:0] f_sig;
    logic [FXW-1:0] f_fx;
    logic [IW-1:0] f_int, f_res, f_sat_pos, f_sat_neg;
    logic [IW:0] f_mag;
    FFlags_Path f_flags;

    function automatic FpClass classify(input logic [FW-1:0] x);
        FpClass c;
        c = '0;
        c.sign = x[FW-1];
        if (&x[FW-2:MW]) begin
            c.is_inf = ~|x[MW-1:0];
            c.is_qnan = x[MW-1];
            c.is_snan = ~x[MW-1] & (|x[MW-1:0]);
        end else if (~|x[FW-2:MW]) begin
            c.is_zero = ~|x[MW-1:0];
            c.is_sub = |x[MW-1:0];
        end else begin
            c.is_norm = 1'b1;
        end
        return c;
    endfunction

    function automatic logic [IW-1:0] box(input logic [FW-1:0] x);
        logic [IW-1:0] r;
        r = '1;
        r[FW-1:0] = x;
        return r;
    endfunction

    // A register that is not properly NaN-boxed reads as canonical NaN.
    function automatic logic [FW-1:0] unbox(input logic [IW-1:0] x);
        logic [IW-1:0] m;
        m = '0;
        m[FW-1:0] = '1;
        return (&(x | m)) ? x[FW-1:0] : CNAN;
    endfunction

    always_comb begin
        a_f = unbox(lhs);
        b_f = unbox(rhs);
        a_c = classify(a_f);
        b_c = classify(b_f);
        a_nan = a_c.is_snan | a_c.is_qnan;
        b_nan = b_c.is_snan | b_c.is_qnan;
        any_snan = a_c.is_snan | b_c.is_snan;
        eq = (a_f == b_f) | (a_c.is_zero & b_c.is_zero);
        if (a_c.is_zero & b_c.is_zero) lt = 1'b0;
        else if (a_c.sign != b_c.sign) lt = a_c.sign;
        else if (a_c.sign) lt = a_f[FW-2:0] > b_f[FW-2:0];
        else lt = a_f[FW-2:0] < b_f[FW-2:0];
        if (a_nan & b_nan) mm_f = CNAN;
        else if (a_nan) mm_f = b_f;
        else if (b_nan) mm_f = a_f;
        else if (a_c.is_zero & b_c.is_zero)
            mm_f = {(op == FPU_FMAX) ? (a_c.sign & b_c.sign)
                                     : (a_c.sign | b_c.sign),
                    {(FW-1){1'b0}}};
        else mm_f = (lt ^ (op == FPU_FMAX)) ? a_f : b_f;
    end

    always_comb begin
        i2f_sign = (op == FPU_FCVT_SW) & lhs[IW-1];
        i2f_mag = i2f_sign ? (~lhs + IW'(1)) : lhs;
        i2f_t = '0;
        i2f_t[LZC_WIDTH-1 -: IW] = i2f_mag;
        i2f_lz = lzc(i2f_t);
        i2f_norm = i2f_mag << i2f_lz;
        i2f_zero = ~i2f_norm[IW-1];
        i2f_g = i2f_norm[IW-2-MW];
        i2f_s = |(i2f_norm & STK_MASK);
        i2f_up = round_up(rm, i2f_sign, i2f_norm[IW-1-MW], i2f_g, i2f_s);
        i2f_mant = {1'b0, i2f_norm[IW-2 -: MW]} + {{MW{1'b0}}, i2f_up};
        i2f_exp = IW - 1 - int'(i2f_lz) + BIAS + int'(i2f_mant[MW]);
        i2f_res = {i2f_sign, i2f_exp[EW-1:0], i2f_mant[MW-1:0]};
        i2f_flags = '0;
        i2f_flags.nx = i2f_g | i2f_s;
        case (rm)
            RM_RTZ:  i2f_inf = 1'b0;
            RM_RDN:  i2f_inf = i2f_sign;
            RM_RUP:  i2f_inf = ~i2f_sign;
            default: i2f_inf = 1'b1;
        endcase
        if (i2f_zero) begin
            i2f_res = '0;
            i2f_flags = '0;
        end else if (i2f_exp >= EXP_MAX) begin
            i2f_res = {i2f_sign,
                       i2f_inf ? {EW{1'b1}} : {{(EW-1){1'b1}}, 1'b0},
                       i2f_inf ? {MW{1'b0}} : {MW{1'b1}}};
            i2f_flags.of = 1'b1;
            i2f_flags.nx = 1'b1;
        end
    end

    always_comb begin
        f_signed = (op == FPU_FCVT_WS);
        f_sign = a_c.sign;
        f_ue = int'(a_f[FW-2:MW]) - BIAS;
        f_sig = {|a_f[FW-2:MW], a_f[MW-1:0]};
        f_fx = '0;
        f_int = '0;
        f_g = 1'b0;
        f_st = 1'b0;
        f_big = 1'b0;
        // Fixed point with MW+1 fraction bits: value * 2^(MW+1).
        if (f_ue < -1) begin
            f_st = ~a_c.is_zero;
        end else if (f_ue <= IW - 1) begin
            f_fx = {{IW{1'b0}}, f_sig} << (f_ue + 1);
            f_int = f_fx[FXW-1 -: IW];
            f_g = f_fx[MW];
            f_st = |f_fx[MW-1:0];
        end else begin
            f_big = 1'b1;
        end
        f_up = round_up(rm, f_sign, f_int[0], f_g, f_st);
        f_mag = {1'b0, f_int} + {{IW{1'b0}}, f_up};
        f_sat_pos = f_signed ? S_MAX : '1;
        f_sat_neg = f_signed ? S_MIN : '0;
        f_res = '0;
        f_flags = '0;
        if (a_nan) begin
            f_res = f_sat_pos;
            f_flags.nv = 1'b1;
        end else if (a_c.is_inf | f_big) begin
            f_res = f_sign ? f_sat_neg : f_sat_pos;
            f_flags.nv = 1'b1;
        end else if (f_signed) begin
            if (!f_sign && f_mag > S_POS_LIM) begin
                f_res = f_sat_pos;
                f_flags.nv = 1'b1;
            end else if (f_sign && f_mag > S_NEG_LIM) begin
                f_res = f_sat_neg;
                f_flags.nv = 1'b1;
            end else begin
                f_res = f_sign ? -f_mag[IW-1:0] : f_mag[IW-1:0];
                f_flags.nx = f_g | f_st;
            end
        end else if (f_sign) begin
            f_flags.nv = |f_mag;
            f_flags.nx = ~|f_mag & (f_g | f_st);
        end else if (f_mag[IW]) begin
            f_res = f_sat_pos;
            f_flags.nv = 1'b1;
        end else begin
            f_res = f_mag[IW-1:0];
            f_flags.nx = f_g | f_st;
        end
    end

    always_comb begin
        result = '0;
        fflags = '0;
        case (op)
            FPU_FSGNJ:  result = box({b_f[FW-1], a_f[FW-2:0]});
            FPU_FSGNJN: result = box({~b_f[FW-1], a_f[FW-2:0]});
            FPU_FSGNJX: result = box({a_f[FW-1] ^ b_f[FW-1], a_f[FW-2:0]});
            FPU_FMIN, FPU_FMAX: begin
                result = box(mm_f);
                fflags.nv = any_snan;
            end
            FPU_FEQ: begin
                result = {{(IW-1){1'b0}}, eq & ~a_nan & ~b_nan};
                fflags.nv = any_snan;
            end
            FPU_FLT, FPU_FLE: begin
                fflags.nv = a_nan | b_nan;
                result = {{(IW-1){1'b0}},
                          ~(a_nan | b_nan) & (lt | ((op == FPU_FLE) & eq))};
            end
            FPU_FCLASS: begin
                result[9:0] = {a_c.is_qnan, a_c.is_snan,
                               ~a_c.sign & a_c.is_inf,
                               ~a_c.sign & a_c.is_norm,
                               ~a_c.sign & a_c.is_sub,
                               ~a_c.sign & a_c.is_zero,
                               a_c.sign & a_c.is_zero,
                               a_c.sign & a_c.is_sub,
                               a_c.sign & a_c.is_norm,
                               a_c.sign & a_c.is_inf};
                if (a_nan) result[7:0] = '0;
            end
            FPU_FMV_XW, FPU_FMV_WX: result = lhs;
            FPU_FCVT_WS, FPU_FCVT_WUS: begin
                result = f_res;
                fflags = f_flags;
            end
            FPU_FCVT_SW, FPU_FCVT_SWU: begin
                result = box(i2f_res);
                fflags = i2f_flags;
            end
            default: begin
                result = '0;
                fflags = '0;
            end
        endcase
    end

endmodule

// File: rtl/fp_other_pipe.sv
// FP "other" unit: combinational compute, PIPELINE_DEPTH register
// stages with freeze-on-stall, flush, tag pass-through, sticky fflags.
module fp_other_pipe
    import fp_other_pkg::*;
#(
    parameter int EXP_WIDTH      = 8,
    parameter int MANT_WIDTH     = 23,
    parameter int INT_WIDTH      = 32,
    parameter int PIPELINE_DEPTH = 3,
    parameter int TAG_WIDTH      = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  FPU_Code              fpuCode,
    input  Rounding_Mode         rm,
    input  logic [INT_WIDTH-1:0] lhs,
    input  logic [INT_WIDTH-1:0] rhs,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [INT_WIDTH-1:0] result,
    output FFlags_Path           fflags,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 busy,
    output FFlags_Path           fflags_acc,
    input  logic                 fflags_acc_clr
);
    typedef struct packed {
        logic                 valid;
        logic [INT_WIDTH-1:0] result;
        FFlags_Path           fflags;
        logic [TAG_WIDTH-1:0] tag;
    } other_pipe_reg_t;

    localparam int LAST = PIPELINE_DEPTH - 1;

    other_pipe_reg_t pipe_q [PIPELINE_DEPTH];
    other_pipe_reg_t pipe_d [PIPELINE_DEPTH];
    FFlags_Path acc_q, acc_d;
    logic [INT_WIDTH-1:0] c_result;
    FFlags_Path c_flags;
    logic stall, deliver;

    fp_other_compute #(
        .EXP_WIDTH  (EXP_WIDTH),
        .MANT_WIDTH (MANT_WIDTH),
        .INT_WIDTH  (INT_WIDTH)
    ) u_compute (
        .op     (fpuCode),
        .rm     (rm),
        .lhs    (lhs),
        .rhs    (rhs),
        .result (c_result),
        .fflags (c_flags)
    );

    assign out_valid  = pipe_q[LAST].valid;
    assign result     = pipe_q[LAST].result;
    assign fflags     = pipe_q[LAST].fflags;
    assign out_tag    = pipe_q[LAST].tag;
    assign fflags_acc = acc_q;
    assign stall      = out_valid & ~out_ready;
    assign deliver    = out_valid & out_ready;
    assign in_ready   = ~stall;

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < PIPELINE_DEPTH; i++) busy = busy | pipe_q[i].valid;
    end

    // Flush beats stall; a stalled pipe holds every stage in place.
    always_comb begin
        pipe_d = pipe_q;
        if (flush) begin
            for (int i = 0; i < PIPELINE_DEPTH; i++) pipe_d[i] = '0;
        end else if (!stall) begin
            pipe_d[0] = '{valid:  in_valid,
                          result: c_result,
                          fflags: c_flags,
                          tag:    in_tag};
            for (int i = 1; i < PIPELINE_DEPTH; i++) pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (fflags_acc_clr) acc_d = '0;
        if (deliver) acc_d = acc_d | fflags;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPELINE_DEPTH; i++) pipe_q[i] <= '0;
            acc_q <= '0;
        end else begin
            pipe_q <= pipe_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: tb/tb_fp_other_pipe.sv
// Directed bench for fp_other_pipe: conversion, min/max, class,
// compare vectors plus handshake, flush, clear and async reset.
module tb_fp_other_pipe;
    import fp_other_pkg::*;

    localparam logic [4:0] F0 = 5'h00;
    localparam logic [4:0] NX = 5'h01;
    localparam logic [4:0] NV = 5'h10;

    logic clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic busy, fflags_acc_clr;
    FPU_Code fpuCode;
    Rounding_Mode rm;
    logic [31:0] lhs, rhs, result;
    logic [5:0] in_tag, out_tag, tag_ctr;
    FFlags_Path fflags, fflags_acc;

    int nvec, nfail;

    fp_other_pipe dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .fpuCode        (fpuCode),
        .rm             (rm),
        .lhs            (lhs),
        .rhs            (rhs),
        .in_tag         (in_tag),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .fflags         (fflags),
        .out_tag        (out_tag),
        .busy           (busy),
        .fflags_acc     (fflags_acc),
        .fflags_acc_clr (fflags_acc_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string name, input FPU_Code op,
                          input Rounding_Mode r, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er,
                          input logic [4:0] ef);
        int cyc;
        logic got;
        logic [5:0] t;
        @(negedge clk);
        t = tag_ctr;
        tag_ctr = tag_ctr + 6'd1;
        fpuCode = op;
        rm = r;
        lhs = a;
        rhs = b;
        in_tag = t;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) got = 1'b1;
        end
        chk({name, "_lat"}, 32'(cyc), 32'd2);
        chk({name, "_res"}, result, er);
        chk({name, "_flg"}, 32'(fflags), 32'(ef));
        chk({name, "_tag"}, 32'(out_tag), 32'(t));
    endtask

    logic [31:0] hs_a [6];
    logic [31:0] hs_b [6];
    FPU_Code hs_op [6];
    Rounding_Mode hs_rm [6];
    logic [31:0] hs_res [6];
    logic [4:0] hs_flg [6];

    initial begin
        int issued, recv;
        logic accept, saw_nready, seen;
        nvec = 0;
        nfail = 0;
        tag_ctr = 6'd1;
        rst_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        fflags_acc_clr = 1'b0;
        fpuCode = FPU_FSGNJ;
        rm = RM_RNE;
        lhs = '0;
        rhs = '0;
        in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acc", 32'(fflags_acc), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_tag", 32'(out_tag), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("ws_rne", FPU_FCVT_WS, RM_RNE, 32'h40200000, 0, 32'd2, NX);
        run_op("ws_rmm", FPU_FCVT_WS, RM_RMM, 32'h40200000, 0, 32'd3, NX);
        run_op("ws_rup_neg", FPU_FCVT_WS, RM_RUP, 32'hC0200000, 0,
               32'hFFFFFFFE, NX);
        run_op("wus_m1", FPU_FCVT_WUS, RM_RNE, 32'hBF800000, 0, 0, NV);
        run_op("wus_m04", FPU_FCVT_WUS, RM_RTZ, 32'hBECCCCCD, 0, 0, NX);
        run_op("ws_2p31", FPU_FCVT_WS, RM_RNE, 32'h4F000000, 0,
               32'h7FFFFFFF, NV);
        run_op("ws_min", FPU_FCVT_WS, RM_RNE, 32'hCF000000, 0,
               32'h80000000, F0);
        run_op("ws_ninf", FPU_FCVT_WS, RM_RNE, 32'hFF800000, 0,
               32'h80000000, NV);
        run_op("ws_nan", FPU_FCVT_WS, RM_RNE, 32'h7FC00000, 0,
               32'h7FFFFFFF, NV);
        run_op("wus_2p32", FPU_FCVT_WUS, RM_RNE, 32'h4F800000, 0,
               32'hFFFFFFFF, NV);
        run_op("sw_rne", FPU_FCVT_SW, RM_RNE, 32'h01000001, 0,
               32'h4B800000, NX);
        run_op("sw_rup", FPU_FCVT_SW, RM_RUP, 32'h01000001, 0,
               32'h4B800001, NX);
        run_op("sw_m1", FPU_FCVT_SW, RM_RNE, 32'hFFFFFFFF, 0,
               32'hBF800000, F0);
        run_op("swu_max", FPU_FCVT_SWU, RM_RNE, 32'hFFFFFFFF, 0,
               32'h4F800000, NX);
        run_op("sw_zero", FPU_FCVT_SW, RM_RNE, 32'h0, 0, 32'h0, F0);
        run_op("min_qnan", FPU_FMIN, RM_RNE, 32'h7FC00000, 32'h3F800000,
               32'h3F800000, F0);
        run_op("min_snan2", FPU_FMIN, RM_RNE, 32'h7F800001, 32'h7F800001,
               32'h7FC00000, NV);
        run_op("min_zero", FPU_FMIN, RM_RNE, 32'h00000000, 32'h80000000,
               32'h80000000, F0);
        run_op("max_zero", FPU_FMAX, RM_RNE, 32'h80000000, 32'h00000000,
               32'h00000000, F0);
        run_op("class_psub", FPU_FCLASS, RM_RNE, 32'h00000001, 0,
               32'h020, F0);
        run_op("class_ninf", FPU_FCLASS, RM_RNE, 32'hFF800000, 0,
               32'h001, F0);
        run_op("class_snan", FPU_FCLASS, RM_RNE, 32'h7F800001, 0,
               32'h100, F0);
        run_op("feq_zero", FPU_FEQ, RM_RNE, 32'h0, 32'h80000000, 32'd1, F0);
        run_op("feq_qnan", FPU_FEQ, RM_RNE, 32'h7FC00000, 32'h7FC00000,
               32'd0, F0);
        run_op("flt_qnan", FPU_FLT, RM_RNE, 32'h7FC00000, 32'h3F800000,
               32'd0, NV);
        run_op("fle_neg", FPU_FLE, RM_RNE, 32'hBF800000, 32'h3F800000,
               32'd1, F0);
        run_op("sgnjn", FPU_FSGNJN, RM_RNE, 32'h3F800000, 32'h3F800000,
               32'hBF800000, F0);
        run_op("fmv_xw", FPU_FMV_XW, RM_RNE, 32'h12345678, 0,
               32'h12345678, F0);
        run_op("unknown", FPU_Code'(4'hF), RM_RNE, 32'h40200000, 0, 0, F0);

        // Six ops back-to-back with a three-cycle consumer stall.
        hs_op[0] = FPU_FCVT_WS;  hs_rm[0] = RM_RNE; hs_a[0] = 32'h40200000;
        hs_b[0] = 0; hs_res[0] = 32'd2; hs_flg[0] = NX;
        hs_op[1] = FPU_FCVT_WS;  hs_rm[1] = RM_RNE; hs_a[1] = 32'h4F000000;
        hs_b[1] = 0; hs_res[1] = 32'h7FFFFFFF; hs_flg[1] = NV;
        hs_op[2] = FPU_FMIN;     hs_rm[2] = RM_RNE; hs_a[2] = 32'h0;
        hs_b[2] = 32'h80000000; hs_res[2] = 32'h80000000; hs_flg[2] = F0;
        hs_op[3] = FPU_FCVT_SW;  hs_rm[3] = RM_RNE; hs_a[3] = 32'd7;
        hs_b[3] = 0; hs_res[3] = 32'h40E00000; hs_flg[3] = F0;
        hs_op[4] = FPU_FCLASS;   hs_rm[4] = RM_RNE; hs_a[4] = 32'h3F800000;
        hs_b[4] = 0; hs_res[4] = 32'h40; hs_flg[4] = F0;
        hs_op[5] = FPU_FCVT_SW;  hs_rm[5] = RM_RUP; hs_a[5] = 32'h01000001;
        hs_b[5] = 0; hs_res[5] = 32'h4B800001; hs_flg[5] = NX;

        @(negedge clk) fflags_acc_clr = 1'b1;
        @(negedge clk) fflags_acc_clr = 1'b0;
        chk("acc_cleared", 32'(fflags_acc), 32'd0);

        issued = 0;
        recv = 0;
        saw_nready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (issued == 6 && recv == 6) break;
            @(negedge clk);
            out_ready = !(cyc >= 4 && cyc <= 6);
            in_valid = (issued < 6);
            if (issued < 6) begin
                fpuCode = hs_op[issued];
                rm = hs_rm[issued];
                lhs = hs_a[issued];
                rhs = hs_b[issued];
                in_tag = 6'(10 + issued);
            end
            #1;
            if (in_valid && !in_ready) saw_nready = 1'b1;
            if (out_valid && out_ready) begin
                if (recv < 6) begin
                    chk($sformatf("hs%0d_res", recv), result, hs_res[recv]);
                    chk($sformatf("hs%0d_flg", recv), 32'(fflags),
                        32'(hs_flg[recv]));
                    chk($sformatf("hs%0d_tag", recv), 32'(out_tag),
                        32'(10 + recv));
                end else begin
                    chk("hs_extra", 32'(recv), 32'd5);
                end
                recv++;
            end
            accept = in_valid & in_ready;
            @(posedge clk);
            if (accept) issued++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("hs_recv", 32'(recv), 32'd6);
        chk("hs_in_ready_drop", 32'(saw_nready), 32'd1);
        chk("hs_acc", 32'(fflags_acc), 32'(NX | NV));

        // Flush with two ops in flight; the op offered alongside is dropped.
        fpuCode = FPU_FCVT_WS;
        rm = RM_RNE;
        lhs = 32'h3F800000;
        in_tag = 6'd40;
        in_valid = 1'b1;
        @(negedge clk) in_tag = 6'd41;
        @(negedge clk);
        in_tag = 6'd42;
        flush = 1'b1;
        @(posedge clk);
        #1;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_busy", 32'(busy), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_ghost", 32'(seen), 32'd0);
        chk("flush_acc_kept", 32'(fflags_acc), 32'(NX | NV));

        // Clear coinciding with an NX delivery leaves NX only.
        @(negedge clk);
        fpuCode = FPU_FCVT_WS;
        rm = RM_RNE;
        lhs = 32'h40200000;
        in_tag = 6'd50;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("clr_arrived", 32'(seen), 32'd1);
        fflags_acc_clr = 1'b1;
        @(posedge clk);
        #1 fflags_acc_clr = 1'b0;
        chk("clr_with_deliver", 32'(fflags_acc), 32'(NX));

        // Asynchronous reset in the middle of a cycle.
        @(negedge clk);
        lhs = 32'h4F000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_acc", 32'(fflags_acc), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/fp_other_pipe.md
Name: fp_other_pipe

Overview:
- Parametrised successor to the FP32 "other" unit: sign-injection, min/max, compare, classify, move and int<->float conversion.
- Generalised float format (EXP_WIDTH/MANT_WIDTH) and integer width; configurable pipeline depth.
- Valid/ready handshake with backpressure, flush, tag pass-through, and a sticky accrued-fflags register.
- Sits in the FP execution pipe beside the FMA/div units and feeds writeback and the fflags CSR.

Parameters:
- EXP_WIDTH, 8, exponent bits.
- MANT_WIDTH, 23, stored mantissa bits.
- INT_WIDTH, 32, integer operand/result width. Must be >= 1+EXP_WIDTH+MANT_WIDTH (FP_WIDTH).
- PIPELINE_DEPTH, 3, cycles from accept to result. Must be >= 1.
- TAG_WIDTH, 6, opaque tag width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  kill all in-flight ops.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit can accept.
- fpuCode  in  FPU_Code  operation.
- rm  in  Rounding_Mode  rounding mode, already resolved (no DYN).
- lhs  in  INT_WIDTH  operand A; FP values sit in the low FP_WIDTH bits.
- rhs  in  INT_WIDTH  operand B.
- in_tag  in  TAG_WIDTH  tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- result  out  INT_WIDTH  result.
- fflags  out  FFlags_Path  flags of this result.
- out_tag  out  TAG_WIDTH  tag of this result.
- busy  out  1  any stage valid.
- fflags_acc  out  FFlags_Path  sticky OR of fflags of delivered results.
- fflags_acc_clr  in  1  clear fflags_acc.

Behaviour:
- Reset (rst_n low, async): all stage valids 0; out_valid 0; busy 0; fflags_acc 0; result/fflags/out_tag 0. Reset mid-operation discards every in-flight op.
- Stage 0 is combinational compute on the inputs. It is followed by PIPELINE_DEPTH registered stages, each holding {valid, result, fflags, tag}; the output is driven from the last stage.
- An op accepted at edge N (in_valid & in_ready) appears with out_valid=1 in the cycle after edge N+PIPELINE_DEPTH-1, i.e. PIPELINE_DEPTH cycles after acceptance.
- stall = out_valid & ~out_ready. On stall the whole pipe freezes; in_ready = ~stall (no bubble collapsing).
- Delivery = out_valid & out_ready. On each delivery, fflags_acc |= fflags.
- If fflags_acc_clr and a delivery coincide: fflags_acc <= fflags of the delivered op (clear, then OR).
- flush: at the next edge all valids go to 0. An input offered in the flush cycle is dropped. Flush has priority over stall. fflags_acc is unaffected by flush.
- Ops always complete in order; no op is lost or duplicated under any pattern of out_ready.
- Compare (FLT/FLE/FEQ): sign-magnitude order; -0 == +0.
  - FLT/FLE with any NaN operand: result 0, NV.
  - FEQ: NV only for a signalling NaN operand.
  - Boolean results are zero-extended.
- FMIN/FMAX:
  - One NaN operand: return the other operand. Both NaN: return canonical NaN.
  - NV if either operand is an sNaN.
  - FMIN(-0,+0) = -0; FMAX(-0,+0) = +0.
  - Canonical NaN = sign 0, exponent all ones, mantissa MSB 1, rest 0.
- FCLASS: one-hot in bits 9:0, RISC-V order:
  - 0 -inf, 1 -normal, 2 -subnormal, 3 -0, 4 +0, 5 +subnormal, 6 +normal, 7 +inf, 8 sNaN, 9 qNaN.
- FP results: when INT_WIDTH > FP_WIDTH the upper bits are NaN-boxed (all ones). FMV_XW and FMV_WX copy lhs unchanged.
- I2F (FCVT_SW/SWU): exact leading-zero normalisation over INT_WIDTH, then RNE/RTZ/RDN/RUP/RMM on lsb/guard/sticky.
  - A mantissa carry increments the exponent.
  - NX if guard|sticky.
  - Exponent overflow (possible only for small formats) gives ±inf (or max finite per rm) with OF|NX.
  - Zero input gives +0.
- F2I (FCVT_WS/WUS): round per rm, then saturate.
  - NaN gives the max positive value; +inf gives max; -inf gives min (0 for unsigned).
  - Out-of-range, including after rounding, saturates with NV only; NX is suppressed when NV is set.
  - Unsigned with a negative value that rounds to nonzero: result 0, NV. One that rounds to 0: result 0, NX only.
  - Signed exact minimum (e.g. -2^31) gives no NV.
- Unknown fpuCode: result 0, fflags 0; the op still flows through the pipe.

Decomposition:
- Package fp_other_pkg holds:
  - FP_WIDTH and canonical-NaN constants (functions of the parameters);
  - a FpClass struct {is_zero, is_sub, is_norm, is_inf, is_snan, is_qnan, sign};
  - an OtherPipeReg struct {valid, result, fflags, tag};
  - rounding-decision and leading-zero-count functions.
- One sub-module, fp_other_compute, is natural: purely combinational stage 0, parametrised by EXP_WIDTH/MANT_WIDTH/INT_WIDTH.
- The pipe, handshake, flush and fflags_acc stay in the top.

Test Plan:
- FCVT_WS of 0x40200000 (2.5): RNE -> 2 with NX; RMM -> 3 with NX; RUP of 0xC0200000 (-2.5) -> 0xFFFFFFFE with NX.
- FCVT_WUS of 0xBF800000 (-1.0) -> 0 with NV. FCVT_WUS of 0xBECCCCCD (-0.4), RTZ -> 0 with NX. FCVT_WS of 0x4F000000 (2^31) -> 0x7FFFFFFF with NV. FCVT_WS of 0xCF000000 -> 0x80000000 with no flags.
- FCVT_SW of 0x01000001: RNE -> 0x4B800000 with NX; RUP -> 0x4B800001. FCVT_SW of 0xFFFFFFFF -> 0xBF800000 with no flags.
- FMIN(0x7FC00000, 0x3F800000) -> 0x3F800000, flags 0. FMIN(0x7F800001, 0x7F800001) -> 0x7FC00000 with NV. FMIN(0x00000000, 0x80000000) -> 0x80000000. FCLASS 0x00000001 -> 0x020.
- Handshake: 6 back-to-back ops, out_ready=0 for 3 cycles mid-stream -> in_ready drops, all 6 delivered in order with correct tags, and fflags_acc is the OR of their flags. Flush with 2 ops in flight -> out_valid=0 and busy=0 the next cycle.
- Reset pulse low mid-stream -> out_valid, busy and fflags_acc read 0 immediately (async). fflags_acc_clr coincident with a delivery of NX -> fflags_acc = NX only.
